// File: rtl/parity_scan_monitor.sv
// Parity scan monitor: per-sweep pass/error counters, consecutive-error alarm FSM, and a failing-address log FIFO.
// Optional build macro PARITY_MON_RECHECK_EN adds an internal parity recheck that sets a sticky checker_fault.
module parity_scan_monitor #(
  parameter int unsigned SWEEP_LEN    = 16,
  parameter int unsigned LOG_DEPTH    = 4,
  parameter int unsigned ALARM_THRESH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_addr,
  input  logic [7:0] in_data,
  input  logic       in_parity,
  input  logic       in_match,
  input  logic       log_rd,
  input  logic       alarm_clr,
  output logic       log_valid,
  output logic [3:0] log_addr,
  output logic [7:0] log_data,
  output logic       log_overflow,
  output logic [7:0] err_count,
  output logic [7:0] pass_count,
  output logic       sweep_done,
  output logic       alarm,
  output logic       checker_fault
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CONS_W   = 4;
  localparam int unsigned SW_W     = $clog2(SWEEP_LEN + 1);
  localparam int unsigned PTR_W    = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam int unsigned OCC_W    = $clog2(LOG_DEPTH + 1);
  localparam int unsigned ENTRY_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ALARM = 2'd2
  } state_e;

  state_e               state_q;
  logic                 alarm_q;
  logic [SW_W-1:0]      sweep_q, sweep_d;
  logic                 sweep_done_q, sweep_done_d;
  logic [CNT_W-1:0]     pass_q, pass_d, err_q, err_d;
  logic [CNT_W-1:0]     pass_base, err_base;
  logic [CONS_W-1:0]    consec_q, consec_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 overflow_q, overflow_d;
  logic [ENTRY_W-1:0]   mem_q [LOG_DEPTH];

  logic mism, matched, full, push, pop, drop, hit;

  assign matched = in_valid & in_match;
  assign mism    = in_valid & ~in_match;
  assign full    = (occ_q == OCC_W'(LOG_DEPTH));
  assign pop     = log_rd & (occ_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full log still lands.
  assign push    = mism & (~full | pop);
  assign drop    = mism & full & ~pop;
  assign hit     = mism & ((({1'b0, consec_q}) + 5'd1) >= 5'(ALARM_THRESH));

  always_comb begin
    sweep_d      = sweep_q;
    sweep_done_d = 1'b0;
    pass_base    = sweep_done_q ? '0 : pass_q;
    err_base     = sweep_done_q ? '0 : err_q;
    pass_d       = pass_base;
    err_d        = err_base;
    consec_d     = consec_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    overflow_d   = overflow_q | drop;

    if (in_valid) begin
      if (sweep_q == SW_W'(SWEEP_LEN - 1)) begin
        sweep_d      = '0;
        sweep_done_d = 1'b1;
      end else begin
        sweep_d = sweep_q + SW_W'(1);
      end
    end

    if (matched && (pass_base != '1)) pass_d = pass_base + CNT_W'(1);
    if (mism && (err_base != '1))     err_d  = err_base + CNT_W'(1);

    if (alarm_clr) begin
      consec_d = '0;
    end else if (in_valid) begin
      if (in_match)               consec_d = '0;
      else if (consec_q != '1)    consec_d = consec_q + CONS_W'(1);
    end

    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(LOG_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(LOG_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_q      <= '0;
      sweep_done_q <= 1'b0;
      pass_q       <= '0;
      err_q        <= '0;
      consec_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sweep_q      <= sweep_d;
      sweep_done_q <= sweep_done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      consec_q     <= consec_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      overflow_q   <= overflow_d;
    end
  end

  // Log storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {in_addr, in_data};
  end

  // Alarm FSM: a threshold hit wins over a simultaneous alarm_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      alarm_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= ALARM;
            alarm_q <= 1'b1;
          end else if (in_valid) begin
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            state_q <= ALARM;
            alarm_q <= 1'b1;
          end
        end
        ALARM: begin
          if (alarm_clr && !hit) begin
            state_q <= SCAN;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_MON_RECHECK_EN
  logic fault_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (in_valid && (((^in_data) == in_parity) != in_match)) begin
      fault_q <= 1'b1;
    end
  end
  assign checker_fault = fault_q;
`else
  logic unused_parity;
  assign unused_parity = in_parity;
  assign checker_fault = 1'b0;
`endif

  assign log_valid    = (occ_q != '0);
  assign log_addr     = mem_q[rd_ptr_q][11:8];
  assign log_data     = mem_q[rd_ptr_q][7:0];
  assign log_overflow = overflow_q;
  assign err_count    = err_q;
  assign pass_count   = pass_q;
  assign sweep_done   = sweep_done_q;
  assign alarm        = alarm_q;

endmodule
